seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the fixed-pattern sequence detectors in the RTL sources.
- Pattern, pattern length (1..MAX_LEN) and overlap mode are loaded through a config strobe.
- The input stream is qualified by a valid flag.
- Each match produces a registered one-cycle pulse and increments a saturating match counter.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 16, width of the saturating match counter
LEN_W, $clog2(MAX_LEN+1), derived width of the length field (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cfg_load  input  1  one-cycle strobe that loads cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 = first bit expected, bit 0 = last bit expected
cfg_len  input  LEN_W  pattern length; valid range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
in_valid  input  1  in is sampled only when high
in  input  1  serial data bit
count_clr  input  1  synchronous clear of match_count
detected  output  1  registered one-cycle pulse per match
match_count  output  CNT_W  number of matches, saturating at all-ones
cfg_err  output  1  sticky flag: last load had cfg_len=0 or cfg_len>MAX_LEN
armed  output  1  high when a valid config is held (state != UNCFG)

Behaviour:
- Reset (rst_n low, asynchronous): state=UNCFG; history=0; fill_cnt=0; pattern/len/overlap regs=0; detected=0; match_count=0; cfg_err=0; armed=0.
- States: UNCFG (no valid config), FILL (fill_cnt < len), RUN (history holds >= len valid bits).
- History: MAX_LEN-bit shift register, hist <= {hist[MAX_LEN-2:0], in} on each in_valid while not UNCFG. fill_cnt increments, saturating at len.
- Match test, on the completing bit: next-history bits [len-1:0] == pattern[len-1:0] AND (fill_cnt+1 >= len).
  - Evaluated in FILL (on the bit that completes the fill) and in RUN.
  - Bits above len are ignored.
- On a match:
  - detected=1 in the following cycle for exactly one cycle (latency 1 clk after the completing bit is sampled).
  - match_count+1, holding at 2^CNT_W-1.
- Overlap=1: remain in or enter RUN; every subsequent valid bit is tested.
- Overlap=0: fill_cnt<=0 and go to FILL. The completing bit is consumed and is not reused.
- len=1: every valid bit equal to pattern[0] matches; overlap mode is irrelevant.
- in_valid=0: no shift, no test, detected=0 next cycle.
- cfg_load handling:
  - Valid length: latch pattern/len/overlap, clear history and fill_cnt, go to FILL, cfg_err<=0.
  - Invalid length: go to UNCFG, cfg_err<=1; previous config discarded.
  - match_count is unaffected either way.
- cfg_load together with in_valid: load wins; that input bit is discarded and no match is tested.
- count_clr together with a match: clear wins, match_count=0. detected still pulses.
- UNCFG: inputs ignored; detected stays 0.
- Reset mid-stream: all state cleared immediately; no pulse is generated from partial history after rst_n rises.

Decomposition:
- Package seq_det_pkg holds the state enum (UNCFG, FILL, RUN), the MAX_LEN default and the LEN_W helper function.
- One natural sub-module: sat_counter (parametrised width, inc, clr-priority, saturate), reusable by other detectors.
- The shift/compare/FSM logic stays in the top module.

Test Plan:
1. Reset, load pattern=4'b0011 len=4 overlap=1, stream 0,0,1,1 (in_valid=1) -> detected pulses one cycle after 4th bit; match_count=1; armed=1.
2. Load 4'b1101 len=4 overlap=1, stream 1,1,0,1,1,0,1 -> pulses after bits 4 and 7, match_count=2. Repeat with overlap=0 -> single pulse after bit 4, match_count=1.
3. Load len=0, then len=MAX_LEN+1 -> cfg_err=1, armed=0, stream containing the old pattern gives no pulses. Reload len=3 -> cfg_err=0.
4. Pattern 0011 len 4: stream 0,0,1 with in_valid gaps of 3 idle cycles, then 1 -> exactly one pulse, one cycle after the final valid bit; no pulses during gaps.
5. CNT_W=4, len=1 pattern 1, stream 20 ones -> match_count stops at 15. Assert count_clr on a match cycle -> count=0, detected still pulses.
6. Mid-pattern events: assert rst_n low after bits 0,0,1 then complete with 1 -> no pulse, all outputs 0. Separately, cfg_load in the same cycle as the completing bit -> no pulse, history cleared.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ============================================================================
// seq_det_pkg : shared types and helpers for the programmable sequence detector
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 8;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter, synchronous clear has priority
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
// seq_detector_prog : runtime-programmable serial bit-pattern detector
// Revision          : 1.0
// ============================================================================
`default_nettype none

module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               count_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             r_state;
  state_t             w_state_next;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_detected;
  logic               r_cfg_err;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_len_mask;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_fill_ok;
  logic               w_cfg_valid;
  logic               w_shift;
  logic               w_match;

  assign w_hist_next = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
  assign w_fill_ok   = (w_fill_inc >= {1'b0, r_len});
  assign w_cfg_valid = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A load in the same cycle as a valid bit discards that bit.
  assign w_shift     = in_valid && !cfg_load && (r_state != ST_UNCFG);

  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_len_mask[i] = (i < int'(r_len));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNCFG;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (cfg_load) begin
      w_state_next = w_cfg_valid ? ST_FILL : ST_UNCFG;
    end else if (w_shift) begin
      if (w_match) begin
        w_state_next = r_overlap ? ST_RUN : ST_FILL;
      end else if (w_fill_ok) begin
        w_state_next = ST_RUN;
      end
    end
  end

  // Output / match logic
  always_comb begin
    w_match = w_shift && w_fill_ok &&
              (((w_hist_next ^ r_pattern) & w_len_mask) == '0);
    armed   = (r_state != ST_UNCFG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist     <= '0;
      r_fill     <= '0;
      r_pattern  <= '0;
      r_len      <= '0;
      r_overlap  <= 1'b0;
      r_detected <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_detected <= w_match;
      if (cfg_load) begin
        r_hist <= '0;
        r_fill <= '0;
        if (w_cfg_valid) begin
          r_pattern <= cfg_pattern;
          r_len     <= cfg_len;
          r_overlap <= cfg_overlap;
          r_cfg_err <= 1'b0;
        end else begin
          r_pattern <= '0;
          r_len     <= '0;
          r_overlap <= 1'b0;
          r_cfg_err <= 1'b1;
        end
      end else if (w_shift) begin
        r_hist <= w_hist_next;
        if (w_match && !r_overlap) begin
          r_fill <= '0;
        end else if (w_fill_ok) begin
          r_fill <= r_len;
        end else begin
          r_fill <= w_fill_inc[LEN_W-1:0];
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_match),
    .clr   (count_clr),
    .count (match_count)
  );

  assign detected = r_detected;
  assign cfg_err  = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
// tb_seq_detector_prog : directed self-checking bench for seq_detector_prog
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               in;
  logic               count_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  int checks = 0;
  int errors = 0;

  seq_detector_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in          (in),
    .count_clr   (count_clr),
    .detected    (detected),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  // Drive one valid bit, then check the detected pulse that follows it.
  task automatic bit_chk(input logic b, input logic exp_det, input string tag);
    in_valid = 1'b1;
    in       = b;
    tick();
    in_valid = 1'b0;
    in       = 1'b0;
    chk(tag, 32'(detected), 32'(exp_det));
  endtask

  task automatic idle_chk(input string tag);
    tick();
    chk(tag, 32'(detected), 32'd0);
  endtask

  task automatic clr_count();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in          = 1'b0;
    count_clr   = 1'b0;
    repeat (3) tick();
    chk("rst_detected", 32'(detected), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic 0011 match
    load(8'b0011, 4'd4, 1'b1);
    chk("t1_armed", 32'(armed), 32'd1);
    chk("t1_cfg_err", 32'(cfg_err), 32'd0);
    bit_chk(1'b0, 1'b0, "t1_b1");
    bit_chk(1'b0, 1'b0, "t1_b2");
    bit_chk(1'b1, 1'b0, "t1_b3");
    bit_chk(1'b1, 1'b1, "t1_b4");
    chk("t1_count", 32'(match_count), 32'd1);
    idle_chk("t1_pulse_end");

    // 2: 1101 overlapping vs non-overlapping, stream 1101101
    clr_count();
    chk("t2_clr", 32'(match_count), 32'd0);
    load(8'b1101, 4'd4, 1'b1);
    bit_chk(1'b1, 1'b0, "t2o_b1");
    bit_chk(1'b1, 1'b0, "t2o_b2");
    bit_chk(1'b0, 1'b0, "t2o_b3");
    bit_chk(1'b1, 1'b1, "t2o_b4");
    bit_chk(1'b1, 1'b0, "t2o_b5");
    bit_chk(1'b0, 1'b0, "t2o_b6");
    bit_chk(1'b1, 1'b1, "t2o_b7");
    chk("t2o_count", 32'(match_count), 32'd2);
    clr_count();
    load(8'b1101, 4'd4, 1'b0);
    bit_chk(1'b1, 1'b0, "t2n_b1");
    bit_chk(1'b1, 1'b0, "t2n_b2");
    bit_chk(1'b0, 1'b0, "t2n_b3");
    bit_chk(1'b1, 1'b1, "t2n_b4");
    bit_chk(1'b1, 1'b0, "t2n_b5");
    bit_chk(1'b0, 1'b0, "t2n_b6");
    bit_chk(1'b1, 1'b0, "t2n_b7");
    chk("t2n_count", 32'(match_count), 32'd1);

    // 3: invalid lengths
    load(8'b1101, 4'd0, 1'b1);
    chk("t3_len0_err", 32'(cfg_err), 32'd1);
    chk("t3_len0_armed", 32'(armed), 32'd0);
    bit_chk(1'b1, 1'b0, "t3_b1");
    bit_chk(1'b1, 1'b0, "t3_b2");
    bit_chk(1'b0, 1'b0, "t3_b3");
    bit_chk(1'b1, 1'b0, "t3_b4");
    load(8'b1101, 4'd9, 1'b1);
    chk("t3_len9_err", 32'(cfg_err), 32'd1);
    chk("t3_len9_armed", 32'(armed), 32'd0);
    bit_chk(1'b1, 1'b0, "t3_c1");
    bit_chk(1'b1, 1'b0, "t3_c2");
    bit_chk(1'b0, 1'b0, "t3_c3");
    bit_chk(1'b1, 1'b0, "t3_c4");
    chk("t3_count_kept", 32'(match_count), 32'd1);
    load(8'b101, 4'd3, 1'b1);
    chk("t3_reload_err", 32'(cfg_err), 32'd0);
    chk("t3_reload_armed", 32'(armed), 32'd1);
    bit_chk(1'b1, 1'b0, "t3_d1");
    bit_chk(1'b0, 1'b0, "t3_d2");
    bit_chk(1'b1, 1'b1, "t3_d3");

    // 4: in_valid gaps
    clr_count();
    load(8'b0011, 4'd4, 1'b1);
    bit_chk(1'b0, 1'b0, "t4_b1");
    repeat (3) idle_chk("t4_gap1");
    bit_chk(1'b0, 1'b0, "t4_b2");
    repeat (3) idle_chk("t4_gap2");
    bit_chk(1'b1, 1'b0, "t4_b3");
    repeat (3) idle_chk("t4_gap3");
    bit_chk(1'b1, 1'b1, "t4_b4");
    idle_chk("t4_after");
    chk("t4_count", 32'(match_count), 32'd1);

    // 5: len=1 saturation, upper pattern bits ignored
    clr_count();
    load(8'b1111_0001, 4'd1, 1'b0);
    bit_chk(1'b0, 1'b0, "t5_zero");
    for (int i = 0; i < 20; i++) begin
      bit_chk(1'b1, 1'b1, "t5_one");
      chk("t5_count", 32'(match_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    count_clr = 1'b1;
    bit_chk(1'b1, 1'b1, "t5_clr_det");
    count_clr = 1'b0;
    chk("t5_clr_count", 32'(match_count), 32'd0);
    bit_chk(1'b1, 1'b1, "t5_post_clr");
    chk("t5_post_count", 32'(match_count), 32'd1);

    // 6a: asynchronous reset mid-pattern
    load(8'b0011, 4'd4, 1'b1);
    bit_chk(1'b0, 1'b0, "t6_b1");
    bit_chk(1'b0, 1'b0, "t6_b2");
    bit_chk(1'b1, 1'b0, "t6_b3");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(match_count), 32'd0);
    chk("t6_async_armed", 32'(armed), 32'd0);
    tick();
    rst_n = 1'b1;
    bit_chk(1'b1, 1'b0, "t6_b4");
    chk("t6_count", 32'(match_count), 32'd0);
    chk("t6_armed", 32'(armed), 32'd0);
    chk("t6_cfg_err", 32'(cfg_err), 32'd0);

    // 6b: load collides with the completing bit
    load(8'b0011, 4'd4, 1'b1);
    bit_chk(1'b0, 1'b0, "t6c_b1");
    bit_chk(1'b0, 1'b0, "t6c_b2");
    bit_chk(1'b1, 1'b0, "t6c_b3");
    in_valid = 1'b1;
    in       = 1'b1;
    load(8'b0011, 4'd4, 1'b1);
    in_valid = 1'b0;
    in       = 1'b0;
    chk("t6c_load_det", 32'(detected), 32'd0);
    bit_chk(1'b1, 1'b0, "t6c_hist_cleared");
    bit_chk(1'b0, 1'b0, "t6c_r1");
    bit_chk(1'b0, 1'b0, "t6c_r2");
    bit_chk(1'b1, 1'b0, "t6c_r3");
    bit_chk(1'b1, 1'b1, "t6c_r4");
    chk("t6c_count", 32'(match_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
